fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side controller for the dual-port FIFO memory (`dual_fifo_mem`) of the asynchronous FIFO. It shares the single memory write port between two requesters using round-robin arbitration. It drives the memory's write address, enable, data and `wfull` inputs. It maintains the binary and Gray write pointers and computes full against the read pointer already synchronized into the write domain.

## Interface

Parameters:
- `data_width`, 8: payload width; matches the memory.
- `add_width`, 4: memory address width; depth = 1<<add_width; pointers are add_width+1 bits.

Ports:
- `wclk`  in  1: write-domain clock; single clock, all state on rising edge.
- `wrst_n`  in  1: asynchronous, active-low reset.
- `req0`  in  1: requester 0 has a word to write.
- `data0`  in  data_width: requester 0 payload.
- `req1`  in  1: requester 1 has a word to write.
- `data1`  in  data_width: requester 1 payload.
- `wq2_rptr`  in  add_width+1: Gray read pointer, already 2-flop synchronized into `wclk`.
- `gnt0`  out  1: requester 0 word accepted this cycle.
- `gnt1`  out  1: requester 1 word accepted this cycle.
- `w_data`  out  data_width: to memory `w_data`.
- `w_add`  out  add_width: to memory `w_add` = wbin[add_width-1:0].
- `wclk_en`  out  1: to memory `wclk_en`; = gnt0 | gnt1.
- `wfull`  out  1: registered full flag; to memory and to requesters.
- `wptr`  out  add_width+1: registered Gray write pointer, to the read-domain synchronizer.

## Operation

- State: `wbin` (add_width+1 binary pointer), `wptr` (Gray), `wfull`, `last` (1 bit, last requester granted).
- Arbitration (combinational, same cycle): if `wfull`, then no grant. If only one request, grant it. If both request, grant the requester ≠ `last`.
- Accept = grant. The requester holds req/data until it sees its grant, and may drop req at any time.
- `w_data` = data of the granted requester; data0 when idle (don't-care, but deterministic).
- On accept: wbin ← wbin+1 (wraps modulo 2^(add_width+1)), `last` ← granted index. With no accept, `last` holds.
- wgray_next = (wbin_next>>1) ^ wbin_next, where wbin_next = wbin + accept.
- wptr ← wgray_next; wfull ← (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
- Full is pessimistic: it deasserts only after the read pointer propagates through the synchronizer. No write is ever issued while `wfull`=1. The memory gating on `wfull` is redundant by design.
- Address wrap: w_add wraps 15→0 (add_width=4); the pointer MSB toggles each wrap.

## Timing

- Reset (async assert, sync release is the system's duty): wbin=0, wptr=0, wfull=0, last=1 (requester 0 first), gnt0=gnt1=0 when no req.
- Grant and wclk_en are combinational from req/wfull/last. The memory write occurs on the same `wclk` edge.
- Pointer, `wptr` and `wfull` update on the edge of the accept. `wfull` is visible the cycle after the filling write, so the 16th write in a burst sets wfull immediately after.
- Simultaneous req0 & req1 held continuously: grants alternate every cycle.
- Reset mid-burst: outputs return to reset values immediately. The in-flight word is not written unless the edge preceded reset.
- Full and read pointer advance in the same cycle: no write that cycle. wfull clears on the first edge after wq2_rptr changes.

## Structure

- Shared package: `data_width`/`add_width` defaults and a Gray-encode function bin2gray (also used by the read-side controller).
- Natural sub-module: `rr_arb2` (2-way round-robin arbiter: req[1:0], last, enable → gnt[1:0]). Pointer/full logic stays in the top.
- Top instantiates nothing else. The memory and synchronizers are siblings at the FIFO top level.

## Test plan

- Reset, then req0 only with data 0xA0..0xAF for 16 cycles, rptr=0: gnt0 each cycle, w_add 0..15, wfull=1 after the 16th edge, wptr=5'b11000. A 17th req0 gets no grant and wclk_en=0.
- Both requesters held from reset: grants go 0,1,0,1…; w_data alternates data0/data1; w_add increments by 1 per cycle.
- Full, then wq2_rptr steps to Gray(1)=5'b00001: wfull clears on the next edge, and exactly one more write is accepted at w_add=0, with wptr MSB toggled.
- Wrap: 40 writes interleaved with rptr tracking wptr−2: no wfull, w_add wraps 15→0 twice, and wptr always matches bin2gray(write count mod 32).
- Assert wrst_n low mid-burst between edges: wptr, wfull and w_add go to 0 immediately. After release, req1 alone is granted at w_add=0.
- Requester drops req before a grant (other one granted): no write of the dropped word, and `last` is unaffected by the dropped request.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the asynchronous FIFO controllers.
//   DATA_WIDTH / ADD_WIDTH : default payload and memory address widths
//   req_id_t               : identifies which write requester was granted last
//   bin2gray               : binary to Gray conversion. The read-side controller
//                            uses it too. Callers size-cast the result down to
//                            their pointer width.
// -----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADD_WIDTH  = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  // Works on a wide word so that any pointer width up to 32 bits can share it.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. It is purely combinational.
//   req[1:0] : requests from requester 1 and requester 0
//   last     : index of the requester that was granted most recently
//   enable   : grants are allowed only while this is high (the FIFO is not full)
//   gnt[1:0] : one-hot grant, or zero
// -----------------------------------------------------------------------------
module rr_arb2
  import fifo_wr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] gnt
);

  // A lone request always wins. When both requesters ask at the same time,
  // the one that was not served last gets the grant. Held requests therefore
  // alternate every cycle.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == REQ1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Write-side controller of the asynchronous FIFO. Two requesters share the
// single write port of the memory through round-robin arbitration. This module
// keeps the binary and Gray write pointers and the registered full flag.
//   wclk, wrst_n    : write clock, asynchronous active-low reset
//   req0/data0      : requester 0 handshake and payload
//   req1/data1      : requester 1 handshake and payload
//   wq2_rptr        : Gray read pointer, already synchronized into wclk
//   gnt0/gnt1       : word accepted this cycle (combinational)
//   w_data, w_add   : memory write data and address
//   wclk_en         : memory write enable
//   wfull           : registered full flag
//   wptr            : registered Gray write pointer, sent to the read domain
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int add_width  = ADD_WIDTH
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  req0,
  input  logic [data_width-1:0] data0,
  input  logic                  req1,
  input  logic [data_width-1:0] data1,
  input  logic [add_width:0]    wq2_rptr,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [data_width-1:0] w_data,
  output logic [add_width-1:0]  w_add,
  output logic                  wclk_en,
  output logic                  wfull,
  output logic [add_width:0]    wptr
);

  logic [add_width:0] wbin;
  logic [add_width:0] wbin_next;
  logic [add_width:0] wgray_next;
  logic [add_width:0] full_ptr;
  logic [1:0]         gnt;
  logic               accept;
  req_id_t            last;

  rr_arb2 u_arb (
    .req    ({req1, req0}),
    .last   (last),
    .enable (~wfull),
    .gnt    (gnt)
  );

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign accept  = gnt[0] | gnt[1];
  assign wclk_en = accept;
  assign w_add   = wbin[add_width-1:0];

  // When nothing is granted, data0 goes to the memory. The value is unused
  // then, but it stays deterministic.
  assign w_data = gnt[1] ? data1 : data0;

  assign wbin_next  = wbin + (add_width + 1)'(accept);
  assign wgray_next = (add_width + 1)'(bin2gray(32'(wbin_next)));

  // The write pointer is exactly one lap ahead of the read pointer. In Gray
  // code this means the top two bits are inverted and the rest are equal.
  assign full_ptr = {~wq2_rptr[add_width -: 2], wq2_rptr[add_width-2:0]};

  // Pointers and the full flag advance together on the accepting edge. Full is
  // evaluated again on every edge, so it clears one edge after the
  // synchronized read pointer moves.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
      last  <= REQ1;
    end else begin
      wbin  <= wbin_next;
      wptr  <= wgray_next;
      wfull <= (wgray_next == full_ptr);
      if (accept) begin
        last <= gnt[1] ? REQ1 : REQ0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (data_width=8, add_width=4).
// It applies a fixed vector table for the fill / full / drain corner. It then
// runs hand-written sequences and random traffic against a reference model
// that counts writes and reads.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [4:0] wq2_rptr = 5'b0;
  logic       gnt0, gnt1, wclk_en, wfull;
  logic [7:0] w_data;
  logic [3:0] w_add;
  logic [4:0] wptr;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: total words written, total words read, the last
  // requester served, and the full flag the design should currently show.
  int m_wcount;
  int m_rcount;
  bit m_last;
  bit m_full;

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         rc;
    bit         g0;
    bit         g1;
    logic [3:0] add;
    bit         full;
    logic [4:0] ptr;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs[20];

  fifo_wr_arbiter #(.data_width(8), .add_width(4)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req0     (req0),
    .data0    (data0),
    .req1     (req1),
    .data1    (data1),
    .wq2_rptr (wq2_rptr),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .w_data   (w_data),
    .w_add    (w_add),
    .wclk_en  (wclk_en),
    .wfull    (wfull),
    .wptr     (wptr)
  );

  always #5 wclk = ~wclk;

  // Gray code of a count taken modulo 32.
  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_wcount = 0;
    m_rcount = 0;
    m_last   = 1'b1;
    m_full   = 1'b0;
  endtask

  // One cycle of the model-checked stimulus. The task is called at posedge+1.
  // It returns at the next posedge+1 with the model advanced.
  task automatic applyStimulus(input bit r0, input logic [7:0] d0,
                               input bit r1, input logic [7:0] d1, input int rc);
    bit eg0, eg1;
    req0 = r0; data0 = d0; req1 = r1; data1 = d1;
    m_rcount = rc;
    wq2_rptr = gray5(rc);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!m_full) begin
      if (r0 && r1) begin
        if (m_last) eg0 = 1'b1;
        else        eg1 = 1'b1;
      end else begin
        eg0 = r0;
        eg1 = r1;
      end
    end
    #2;
    checkOutput("gnt0",    32'(gnt0),    32'(eg0));
    checkOutput("gnt1",    32'(gnt1),    32'(eg1));
    checkOutput("wclk_en", 32'(wclk_en), 32'(eg0 | eg1));
    checkOutput("w_data",  32'(w_data),  32'(eg1 ? d1 : d0));
    checkOutput("w_add",   32'(w_add),   32'(m_wcount % 16));
    checkOutput("wfull",   32'(wfull),   32'(m_full));
    checkOutput("wptr",    32'(wptr),    32'(gray5(m_wcount)));
    @(posedge wclk);
    #1;
    if (eg0 || eg1) begin
      m_wcount++;
      m_last = eg1;
    end
    m_full = ((m_wcount - m_rcount) % 32) == 16;
  endtask

  // Reset between sections. Release lands on a falling edge, away from the
  // active edge.
  task automatic doReset();
    req0 = 1'b0; req1 = 1'b0; wq2_rptr = 5'b0;
    wrst_n = 1'b0;
    #4;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    modelReset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int wtotal;
    int rtotal;

    // Vector table: fill 16 words from requester 0 with the read pointer at 0.
    // Then check full blocking, the read pointer stepping to Gray(1), the one
    // write that it allows, and full setting again.
    for (int i = 0; i < 20; i++) begin
      vecs[i].r0   = 1'b1;
      vecs[i].r1   = 1'b0;
      vecs[i].d0   = 8'hA0 + 8'(i);
      vecs[i].d1   = 8'h55;
      vecs[i].rc   = (i >= 17) ? 1 : 0;
      vecs[i].g0   = (i < 16) || (i == 18);
      vecs[i].g1   = 1'b0;
      vecs[i].add  = (i < 16) ? 4'(i) : ((i == 19) ? 4'd1 : 4'd0);
      vecs[i].full = (i == 16) || (i == 17) || (i == 19);
      vecs[i].ptr  = (i < 16) ? gray5(i) : ((i == 19) ? 5'b11001 : 5'b11000);
      vecs[i].wd   = vecs[i].d0;
    end

    // Reset state, checked before release.
    #3;
    checkOutput("reset_wptr",  32'(wptr),  32'h0);
    checkOutput("reset_wfull", 32'(wfull), 32'h0);
    checkOutput("reset_w_add", 32'(w_add), 32'h0);
    checkOutput("reset_gnt",   32'({gnt1, gnt0}), 32'h0);
    #9;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    modelReset();

    for (int i = 0; i < 20; i++) begin
      req0 = vecs[i].r0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; data1 = vecs[i].d1;
      wq2_rptr = gray5(vecs[i].rc);
      #2;
      checkOutput("vec_gnt0",    32'(gnt0),    32'(vecs[i].g0));
      checkOutput("vec_gnt1",    32'(gnt1),    32'(vecs[i].g1));
      checkOutput("vec_wclk_en", 32'(wclk_en), 32'(vecs[i].g0 | vecs[i].g1));
      checkOutput("vec_w_add",   32'(w_add),   32'(vecs[i].add));
      checkOutput("vec_wfull",   32'(wfull),   32'(vecs[i].full));
      checkOutput("vec_wptr",    32'(wptr),    32'(vecs[i].ptr));
      checkOutput("vec_w_data",  32'(w_data),  32'(vecs[i].wd));
      @(posedge wclk);
      #1;
    end

    // Both requesters held from reset: grants alternate 0,1,0,1...
    doReset();
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1, 8'h80 + 8'(i), 0);

    // Wrap: 40 writes with the read pointer trailing by two. Full never sets.
    doReset();
    wtotal = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 8'(~i), (m_wcount >= 2) ? m_wcount - 2 : 0);
    end
    checkOutput("wrap_count", 32'(m_wcount), 32'd40);

    // Requester 1 drops before it is served. Only requester 0 writes, and
    // the next contested cycle still goes to requester 1.
    doReset();
    applyStimulus(1'b1, 8'h31, 1'b1, 8'hD1, 0);
    applyStimulus(1'b1, 8'h32, 1'b0, 8'hD1, 0);
    applyStimulus(1'b1, 8'h33, 1'b1, 8'hD2, 0);
    checkOutput("drop_last", 32'(m_last), 32'd1);

    // Reset asserted between edges in the middle of a burst.
    doReset();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 8'h40 + 8'(i), 1'b1, 8'h60 + 8'(i), 0);
    wrst_n = 1'b0;
    #1;
    checkOutput("midrst_wptr",  32'(wptr),  32'h0);
    checkOutput("midrst_wfull", 32'(wfull), 32'h0);
    checkOutput("midrst_w_add", 32'(w_add), 32'h0);
    #3;
    req0 = 1'b0;
    req1 = 1'b0;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    modelReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h77, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h78, 0);

    // Random traffic. The read side advances by a random amount, but never
    // past the write count.
    doReset();
    for (int i = 0; i < 400; i++) begin
      wtotal = m_wcount;
      rtotal = m_rcount;
      if (rtotal < wtotal && $urandom_range(0, 2) == 0)
        rtotal = rtotal + int'($urandom_range(1, wtotal - rtotal));
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), rtotal);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
